// File: rtl/fetch_unit_pkg.sv
// Shared fetch/pipeline definitions: FSM encoding, NOP word and PC width default.
package fetch_unit_pkg;
  localparam int          PC_W_DEF = 13;
  localparam logic [31:0] NOP      = 32'h0;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats load; neither asserted means hold.
import fetch_unit_pkg::*;

module if_id_reg #(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            bubble,
  input  logic [31:0]     instr_in,
  input  logic [PC_W-1:0] pc_plus1_in,
  output logic [31:0]     instr,
  output logic [PC_W-1:0] pc_plus1,
  output logic            valid
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= NOP;
      pc_plus1 <= '0;
      valid    <= 1'b0;
    end else if (bubble) begin
      instr    <= NOP;
      pc_plus1 <= '0;
      valid    <= 1'b0;
    end else if (load) begin
      instr    <= instr_in;
      pc_plus1 <= pc_plus1_in;
      valid    <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, FILL/RUN/HALT control and IF/ID register.
import fetch_unit_pkg::*;

module fetch_unit #(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] pc,
  input  logic [31:0]     instruction,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_target,
  input  logic            halt_req,
  output logic [31:0]     if_id_instr,
  output logic [PC_W-1:0] if_id_pc_plus1,
  output logic            if_id_valid,
  output logic            halted,
  output logic [15:0]     fetch_count
);
  fetch_state_e    state_q, state_d;
  logic            ifid_load, ifid_bubble;
  logic [PC_W-1:0] pc_d, pc_inc;

  assign pc_inc = pc + {{(PC_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FILL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FILL: state_d = ST_RUN;
      ST_RUN:  if (halt_req) state_d = ST_HALT;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FILL;
    endcase
  end

  // Priority in RUN: halt_req > redirect > stall > sequential fetch.
  always_comb begin
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    pc_d        = pc;
    unique case (state_q)
      ST_FILL: ifid_bubble = 1'b1;
      ST_RUN: begin
        if (halt_req) begin
          ifid_bubble = 1'b1;
        end else if (redirect) begin
          ifid_bubble = 1'b1;
          pc_d        = redirect_target;
        end else if (!stall) begin
          ifid_load = 1'b1;
          pc_d      = pc_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      fetch_count <= '0;
    end else begin
      pc <= pc_d;
      if (ifid_load && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
    end
  end

  assign halted = (state_q == ST_HALT);

  if_id_reg #(.PC_W(PC_W)) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (ifid_load),
    .bubble     (ifid_bubble),
    .instr_in   (instruction),
    .pc_plus1_in(pc_inc),
    .instr      (if_id_instr),
    .pc_plus1   (if_id_pc_plus1),
    .valid      (if_id_valid)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a negedge-registered instruction memory.
module tb_fetch_unit;
  localparam int PC_W = 13;
  localparam int ST_FILL = 0, ST_RUN = 1, ST_HALT = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [PC_W-1:0] pc;
  logic [31:0]     instruction = 32'h0;
  logic            stall = 1'b0, redirect = 1'b0, halt_req = 1'b0;
  logic [PC_W-1:0] redirect_target = '0;
  logic [31:0]     if_id_instr;
  logic [PC_W-1:0] if_id_pc_plus1;
  logic            if_id_valid, halted;
  logic [15:0]     fetch_count;

  fetch_unit #(.PC_W(PC_W), .RESET_PC(13'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instruction(instruction),
    .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
    .halt_req(halt_req), .if_id_instr(if_id_instr), .if_id_pc_plus1(if_id_pc_plus1),
    .if_id_valid(if_id_valid), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<PC_W)-1];
  initial for (int k = 0; k < (1<<PC_W); k++) mem[k] = 32'hA000_0000 + k;
  always @(negedge clk) instruction <= mem[pc];

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic [PC_W-1:0] pp1;
    logic            valid;
    logic            halted;
    logic [15:0]     cnt;
  } exp_t;
  exp_t sb[$];

  int m_state;
  logic [PC_W-1:0] m_pc, m_pp1;
  logic [31:0]     m_instr;
  logic            m_valid;
  logic [15:0]     m_cnt;
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_state = ST_FILL; m_pc = '0; m_pp1 = '0; m_instr = 32'h0; m_valid = 1'b0; m_cnt = '0;
  endtask

  task automatic cmp_all(input string tag, input exp_t e);
    chk({tag, ".pc"}, 32'(pc), 32'(e.pc));
    chk({tag, ".instr"}, if_id_instr, e.instr);
    chk({tag, ".valid"}, 32'(if_id_valid), 32'(e.valid));
    if (e.valid) chk({tag, ".pp1"}, 32'(if_id_pc_plus1), 32'(e.pp1));
    chk({tag, ".halted"}, 32'(halted), 32'(e.halted));
    chk({tag, ".cnt"}, 32'(fetch_count), 32'(e.cnt));
  endtask

  // Drive one cycle of inputs, predict the post-edge state, then compare.
  task automatic step(input logic s, input logic r, input logic [PC_W-1:0] t, input logic h);
    exp_t e;
    stall = s; redirect = r; redirect_target = t; halt_req = h;
    case (m_state)
      ST_FILL: begin m_instr = 32'h0; m_valid = 1'b0; m_state = ST_RUN; end
      ST_RUN: begin
        if (h) begin
          m_instr = 32'h0; m_valid = 1'b0; m_state = ST_HALT;
        end else if (r) begin
          m_pc = t; m_instr = 32'h0; m_valid = 1'b0;
        end else if (!s) begin
          m_instr = mem[m_pc]; m_pp1 = m_pc + 13'd1; m_pc = m_pc + 13'd1; m_valid = 1'b1;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
      end
      default: ;
    endcase
    e.pc = m_pc; e.instr = m_instr; e.pp1 = m_pp1; e.valid = m_valid;
    e.halted = (m_state == ST_HALT); e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk); #1;
    cmp_all("step", sb.pop_front());
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".pc"}, 32'(pc), 32'h0);
    chk({tag, ".instr"}, if_id_instr, 32'h0);
    chk({tag, ".pp1"}, 32'(if_id_pc_plus1), 32'h0);
    chk({tag, ".valid"}, 32'(if_id_valid), 32'h0);
    chk({tag, ".halted"}, 32'(halted), 32'h0);
    chk({tag, ".cnt"}, 32'(fetch_count), 32'h0);
  endtask

  initial begin
    logic [PC_W-1:0] frozen;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_vals("reset");
    @(negedge clk); rst_n = 1'b1;

    // Free run: pc 0,1,2,3 and three valid loads.
    for (int i = 0; i < 4; i++) step(0, 0, '0, 0);
    chk("run.pc", 32'(pc), 32'h3);
    chk("run.instr", if_id_instr, 32'hA000_0002);
    chk("run.cnt", 32'(fetch_count), 32'd3);

    step(0, 0, '0, 0); step(0, 0, '0, 0);
    chk("pre_redir.pc", 32'(pc), 32'h5);
    step(0, 1, 13'h0100, 0);
    chk("redir.pc", 32'(pc), 32'h100);
    chk("redir.valid", 32'(if_id_valid), 32'h0);
    step(0, 0, '0, 0);
    chk("redir.instr", if_id_instr, 32'hA000_0100);
    chk("redir.pp1", 32'(if_id_pc_plus1), 32'h101);

    // Stall at pc=7.
    step(0, 1, 13'h0005, 0); step(0, 0, '0, 0); step(0, 0, '0, 0);
    chk("stall.pc0", 32'(pc), 32'h7);
    for (int i = 0; i < 3; i++) step(1, 0, '0, 0);
    chk("stall.pc", 32'(pc), 32'h7);
    chk("stall.instr", if_id_instr, 32'hA000_0006);
    step(1, 1, 13'h0020, 0);
    chk("stall_redir.pc", 32'(pc), 32'h20);
    chk("stall_redir.valid", 32'(if_id_valid), 32'h0);

    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
           13'($urandom_range(0, 8191)), 1'b0);

    // Wrap at the top of the address space.
    step(0, 1, 13'h1FFF, 0);
    step(0, 0, '0, 0);
    chk("wrap.pc", 32'(pc), 32'h0);
    chk("wrap.pp1", 32'(if_id_pc_plus1), 32'h0);
    chk("wrap.instr", if_id_instr, 32'hA000_1FFF);

    // Halt wins over redirect; HALT ignores everything afterwards.
    frozen = pc;
    step(0, 1, 13'h0055, 1);
    chk("halt.halted", 32'(halted), 32'h1);
    chk("halt.pc", 32'(pc), 32'(frozen));
    for (int i = 0; i < 6; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           13'($urandom_range(0, 8191)), 1'($urandom_range(0, 1)));
    chk("halt.valid", 32'(if_id_valid), 32'h0);
    chk("halt.pc_end", 32'(pc), 32'(frozen));

    // Asynchronous reset mid-HALT with a redirect pending.
    redirect = 1'b1; redirect_target = 13'h0077;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    model_reset();
    @(negedge clk); rst_n = 1'b1; redirect = 1'b0;
    step(0, 0, '0, 0); step(0, 0, '0, 0); step(0, 0, '0, 0);
    chk("post_rst.instr", if_id_instr, 32'hA000_0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
